// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_pkg
// Description : Shared types, constants and helpers for the DNN training
//               sequencer. Holds the sequencer state encoding, the
//               cycles-per-case helper and the output pipeline depth.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

    // Sequencer states. The top module mirrors these as fixed-width
    // localparams so the encoding stays stable for legacy consumers.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HOLD = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

    // Cycles between the last input chunk of a block and the last valid
    // DNN output of that block.
    localparam int PIPE_DELAY = 2;

    // Cycles per training case for the first layer: every chunk of the
    // layer-0 activations is fed once, then the pipeline drains.
    function automatic int cpc_calc(input int n0, input int fo0, input int z0);
        return ((n0 * fo0) / z0) + PIPE_DELAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dnn_train_sequencer_error_tally.sv
`default_nettype none
// ============================================================================
// Module      : error_tally
// Description : Per-case output error bookkeeping. A sticky flag collects any
//               a_out/y_out mismatch seen while outputs are valid; at block
//               end it is published as case_err and counted in total_error.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               clear             - clears total_error and the sticky flag
//               out_valid         - DNN outputs meaningful this cycle
//               mismatch          - a_out differs from y_out this cycle
//               block_start       - first cycle of a block
//               block_end         - last cycle of a block
//               case_err          - error flag of the last completed case
//               total_error       - count of cases with an error
// Revision    : 1.0 - initial release
// ============================================================================
module error_tally
    import dnn_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             out_valid,
    input  logic             mismatch,
    input  logic             block_start,
    input  logic             block_end,
    output logic             case_err,
    output logic [CNT_W-1:0] total_error
);

    logic             r_err;
    logic             r_case_err;
    logic [CNT_W-1:0] r_total;
    logic             w_err_now;

    // Error state including this cycle. The flag left over from the previous
    // block is masked on its first cycle, and the mismatch of the final cycle
    // is folded in so block_end sees it without an extra cycle of delay.
    always_comb begin
        w_err_now = ((~block_start) & r_err) | (out_valid & mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_case_err <= 1'b0;
            r_total    <= '0;
        end else begin
            r_err <= w_err_now;
            if (block_end) begin
                r_case_err <= w_err_now;
                if (w_err_now) begin
                    r_total <= r_total + CNT_W'(1);
                end
            end
            if (clear) begin
                r_err   <= 1'b0;
                r_total <= '0;
            end
        end
    end

    assign case_err    = r_case_err;
    assign total_error = r_total;

endmodule
`default_nettype wire

// File: rtl/dnn_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dnn_train_sequencer
// Description : Training-run sequencer for the DNN core. Steps through CPC
//               cycles per case, drives the input chunk select, walks the
//               case-memory index with epoch wrap, stops after a programmed
//               number of cases and tallies per-case output errors.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               start, num_cases      - run start pulse, cases (0 = unbounded)
//               pause                 - hold request, honoured at block end
//               a_out, y_out          - DNN output and delayed ideal output
//               busy, done            - RUN / DONE state indicators
//               cycle_index           - position within the current block
//               feed_valid, chunk_sel - input chunk strobe and mux select
//               out_valid             - DNN outputs meaningful this cycle
//               sel_tc                - case memory index
//               case_done, case_err   - block completion pulse, case error
//               num_train, total_error, epoch - run counters
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_train_sequencer
    import dnn_pkg::*;
#(
    parameter int CPC            = 18,
    parameter int PIPE           = PIPE_DELAY,
    parameter int TRAINING_CASES = 50000,
    parameter int OUT_W          = 1,
    parameter int CNT_W          = 32,
    localparam int NCH           = CPC - PIPE,
    localparam int CYC_W         = (CPC > 2) ? $clog2(CPC) : 1,
    localparam int CHK_W         = (NCH > 2) ? $clog2(NCH) : 1,
    localparam int TC_W          = (TRAINING_CASES > 2) ? $clog2(TRAINING_CASES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cases,
    input  logic             pause,
    input  logic [OUT_W-1:0] a_out,
    input  logic [OUT_W-1:0] y_out,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycle_index,
    output logic             feed_valid,
    output logic [CHK_W-1:0] chunk_sel,
    output logic             out_valid,
    output logic [TC_W-1:0]  sel_tc,
    output logic             case_done,
    output logic             case_err,
    output logic [CNT_W-1:0] num_train,
    output logic [CNT_W-1:0] total_error,
    output logic [CNT_W-1:0] epoch
);

    localparam logic [1:0] c_ST_IDLE = SEQ_IDLE;
    localparam logic [1:0] c_ST_RUN  = SEQ_RUN;
    localparam logic [1:0] c_ST_HOLD = SEQ_HOLD;
    localparam logic [1:0] c_ST_DONE = SEQ_DONE;

    localparam logic [CYC_W-1:0] c_CYC_LAST = CYC_W'(CPC - 1);
    localparam logic [CYC_W-1:0] c_CYC_NCH  = CYC_W'(NCH);
    localparam logic [CYC_W-1:0] c_CYC_PIPE = CYC_W'(PIPE);
    localparam logic [TC_W-1:0]  c_TC_LAST  = TC_W'(TRAINING_CASES - 1);

    logic [1:0]       r_state;
    logic [CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_num_cases;
    logic [CNT_W-1:0] r_num_train;
    logic [CNT_W-1:0] r_epoch;
    logic [TC_W-1:0]  r_sel_tc;
    logic             r_case_done;

    logic             w_run;
    logic             w_block_start;
    logic             w_block_end;
    logic [CNT_W-1:0] w_train_next;
    logic             w_last_case;
    logic             w_tc_last;
    logic             w_start_ok;
    logic             w_feed_valid;
    logic             w_out_valid;
    logic             w_mismatch;

    always_comb begin
        w_run         = (r_state == c_ST_RUN);
        w_block_start = w_run && (r_cyc == '0);
        w_block_end   = w_run && (r_cyc == c_CYC_LAST);
        w_train_next  = r_num_train + CNT_W'(1);
        // Compared on the incremented count so the final case of the run is
        // recognised at its own block end; a zero request never matches.
        w_last_case   = (r_num_cases != '0) && (w_train_next == r_num_cases);
        w_tc_last     = (r_sel_tc == c_TC_LAST);
        w_start_ok    = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        w_feed_valid  = w_run && (r_cyc < c_CYC_NCH);
        w_out_valid   = w_run && (r_cyc >= c_CYC_PIPE);
        w_mismatch    = (a_out != y_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cyc       <= '0;
            r_num_cases <= '0;
            r_num_train <= '0;
            r_epoch     <= '0;
            r_sel_tc    <= '0;
            r_case_done <= 1'b0;
        end else begin
            r_case_done <= w_block_end;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    // The case index is deliberately not cleared here so a
                    // new run continues through case memory where the last
                    // one stopped.
                    if (w_start_ok) begin
                        r_state     <= c_ST_RUN;
                        r_cyc       <= '0;
                        r_num_cases <= num_cases;
                        r_num_train <= '0;
                        r_epoch     <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (w_block_end) begin
                        r_cyc       <= '0;
                        r_num_train <= w_train_next;
                        if (w_tc_last) begin
                            r_sel_tc <= '0;
                            r_epoch  <= r_epoch + CNT_W'(1);
                        end else begin
                            r_sel_tc <= r_sel_tc + TC_W'(1);
                        end
                        // End of run outranks a pending pause.
                        if (w_last_case) begin
                            r_state <= c_ST_DONE;
                        end else if (pause) begin
                            r_state <= c_ST_HOLD;
                        end
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (!pause) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    error_tally #(
        .CNT_W (CNT_W)
    ) u_error_tally (
        .clk         (clk),
        .rst         (reset),
        .clear       (w_start_ok),
        .out_valid   (w_out_valid),
        .mismatch    (w_mismatch),
        .block_start (w_block_start),
        .block_end   (w_block_end),
        .case_err    (case_err),
        .total_error (total_error)
    );

    assign busy        = w_run;
    assign done        = (r_state == c_ST_DONE);
    assign cycle_index = r_cyc;
    assign feed_valid  = w_feed_valid;
    assign chunk_sel   = w_feed_valid ? r_cyc[CHK_W-1:0] : '0;
    assign out_valid   = w_out_valid;
    assign sel_tc      = r_sel_tc;
    assign case_done   = r_case_done;
    assign num_train   = r_num_train;
    assign epoch       = r_epoch;

endmodule
`default_nettype wire

// File: doc/dnn_train_sequencer.md
# dnn_train_sequencer

Controls the training run of the DNN core. It steps through cycles-per-case (cpc) block cycles and produces the chunk select used to feed input activations and ideal outputs. It advances the training-case index with epoch wrap and stops after a programmed case count. It also tallies per-case output mismatches between `a_out` and `y_out`. It replaces the ad-hoc counter, select and error logic currently spread across the MNIST bench, so the same sequencing can drive the DNN from on-chip case memory.

## Interface
- `CPC`, 18: cycles per training case, equal to n[0]*fo[0]/z[0] + 2.
- `PIPE`, 2: drain cycles at the end of each block; chunk count NCH = CPC-PIPE.
- `TRAINING_CASES`, 50000: cases per epoch.
- `OUT_W`, 1: output bits per cycle, equal to z[L-2]/fi[L-2].
- `CNT_W`, 32: width of the `num_train`, `total_error` and `epoch` counters.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a run.
- `num_cases` in CNT_W: cases to run, sampled on `start`; 0 means unbounded.
- `pause` in 1: level; honoured only at block boundaries.
- `a_out` in OUT_W: DNN thresholded output.
- `y_out` in OUT_W: DNN delayed ideal output.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `cycle_index` out clog2(CPC): position within the current block.
- `feed_valid` out 1: current cycle presents a new input chunk.
- `chunk_sel` out clog2(NCH): mux select for `a_in` and `y_in`.
- `out_valid` out 1: DNN outputs are meaningful this cycle.
- `sel_tc` out clog2(TRAINING_CASES): case memory index.
- `case_done` out 1: one-cycle pulse when a block has completed.
- `case_err` out 1: error flag of the last completed case.
- `num_train` out CNT_W: number of completed cases.
- `total_error` out CNT_W: number of cases with an error.
- `epoch` out CNT_W: number of completed epochs.

## Operation
- States are IDLE, RUN, HOLD and DONE.
  - IDLE goes to RUN on `start`.
  - RUN goes to HOLD at a block end when `pause`=1.
  - HOLD goes back to RUN when `pause`=0.
  - RUN goes to DONE at the block end where `num_train`+1 == `num_cases` (with `num_cases` ≠ 0).
  - DONE goes to RUN on `start`, which clears `num_train`, `total_error` and `epoch`; `sel_tc` continues from its current value.
  - `start` in RUN or HOLD is ignored.
- In RUN, `cycle_index` counts 0..CPC-1 and wraps. It holds at 0 in IDLE, HOLD and DONE.
- `feed_valid` = RUN && `cycle_index` < NCH.
- `chunk_sel` = `cycle_index` when `feed_valid`=1, otherwise 0.
- `out_valid` = RUN && `cycle_index` ≥ PIPE, so `out_valid` lasts exactly NCH cycles per block.
- Per-case error is a sticky bit, cleared at `cycle_index`=0 and set on any `out_valid` cycle with `a_out` ≠ `y_out`.
- At block end (`cycle_index`=CPC-1), including the mismatch seen in that same cycle:
  - `case_err` takes the per-case error.
  - `total_error` increments if the error is set.
  - `num_train` increments.
  - `sel_tc` goes to 0 if it equals TRAINING_CASES-1, otherwise increments.
  - `epoch` increments on that wrap.
- All counters are unsigned and wrap modulo 2^CNT_W without saturation.

## Timing
- Reset value is 0 for every output; state goes to IDLE.
- `busy` rises in the cycle after `start`. That cycle is RUN with `cycle_index`=0, `feed_valid`=1 and `chunk_sel`=0.
- `case_done`, `case_err`, `num_train`, `total_error`, `sel_tc` and `epoch` all update together, one cycle after the `cycle_index`=CPC-1 cycle. `case_done` is high for exactly that cycle.
- Per case, back-to-back blocks have no idle cycles and latency is exactly CPC cycles.
- `pause` asserted mid-block takes effect only after `cycle_index`=CPC-1. The block completes with normal bookkeeping, then the block enters HOLD. On release, RUN resumes at `cycle_index`=0 in the next cycle.
- When the end-of-run case and `pause` coincide, DONE has priority.
- `reset` mid-run aborts immediately. Every output returns to 0 in the next cycle, and the partial case is not counted.

## Structure
- Shared package `dnn_pkg` holds:
  - the state enum `seq_state_t`;
  - the function `cpc_calc(n0, fo0, z0)`;
  - the constant `PIPE_DELAY`=2.
- Sub-module `error_tally` holds the sticky per-case flag, `case_err` and `total_error`. Its inputs are `out_valid`, the mismatch signal, the block-start and block-end signals, and `clear`.
- The remaining state machine and counters live in the top module.

## Test plan
- Basic run, with CPC=18, TRAINING_CASES=4, `num_cases`=3 and matching outputs:
  - `busy` is high for 54 cycles;
  - `case_done` is seen 3 times;
  - the run ends with `num_train`=3, `total_error`=0 and `done`=1.
- Select sequence: `chunk_sel` reads 0..15 during cycles 0..15, then `feed_valid`=0 for cycles 16-17. `out_valid` is high for cycles 2..17.
- Error tally: force a single `a_out` ≠ `y_out` at `cycle_index`=17 of case 1 only. Expect `case_err`=1 after case 1 and `total_error`=1; `case_err` returns to 0 after case 2.
- Epoch wrap, with `num_cases`=0 and 9 cases run: `sel_tc` follows 0,1,2,3,0,…,0, and `epoch`=2 after case 8.
- Pause: assert `pause` at `cycle_index`=5 and hold it for 20 cycles.
  - The current case completes at cycle 17 and HOLD is entered.
  - No `case_done` occurs during HOLD.
  - RUN resumes at `cycle_index`=0 one cycle after release.
- Reset and start edge cases:
  - `reset` at `cycle_index`=9 of case 2 makes every output 0 in the next cycle.
  - A `start` during RUN has no effect.
  - A `start` from DONE clears `num_train` to 0.
